// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared widths, entry layout and counter encodings for the BTB
package branch_target_buffer_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Tag is held zero-extended to full width so the layout is independent of ENTRIES.
   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] tag;
      logic [DATA_WIDTH-1:0] target;
      logic [1:0]            ctr;
   } btb_entry_t;

endpackage

// File: rtl/bpred_sat_counter.sv
// rtl/bpred_sat_counter.sv - combinational 2-bit saturating direction counter next-state
module bpred_sat_counter
   import branch_target_buffer_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   input  logic       force_st,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (force_st) begin
         ctr_next = CTR_ST;
      end else if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, async lookup for fetch, clocked update from decode
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] pc_i,
   output logic                  hit_o,
   output logic                  pred_taken_o,
   output logic [DATA_WIDTH-1:0] pred_target_o,
   input  logic                  upd_valid_i,
   input  logic [DATA_WIDTH-1:0] upd_pc_i,
   input  logic [DATA_WIDTH-1:0] upd_imm_i,
   input  logic                  upd_taken_i,
   input  logic                  upd_jump_i,
   input  logic                  flush_i
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

   btb_entry_t tbl [ENTRIES];

   logic [IDX_W-1:0]      lk_idx;
   logic [TAG_W-1:0]      lk_tag;
   btb_entry_t            lk_e;
   logic [IDX_W-1:0]      up_idx;
   logic [TAG_W-1:0]      up_tag;
   btb_entry_t            up_e;
   logic                  up_hit;
   logic                  up_tk;
   logic [1:0]            ctr_base;
   logic [1:0]            ctr_next;
   logic [DATA_WIDTH-1:0] up_target;

   assign lk_idx = pc_i[IDX_W+1:2];
   assign lk_tag = pc_i[DATA_WIDTH-1:IDX_W+2];
   assign lk_e   = tbl[lk_idx];

   // Valid gates everything so uninitialised tag/target never reach the outputs.
   assign hit_o         = lk_e.valid && (lk_e.tag == {{(IDX_W+2){1'b0}}, lk_tag});
   assign pred_taken_o  = hit_o && lk_e.ctr[1];
   assign pred_target_o = pred_taken_o ? lk_e.target : pc_i + DATA_WIDTH'(4);

   assign up_idx    = upd_pc_i[IDX_W+1:2];
   assign up_tag    = upd_pc_i[DATA_WIDTH-1:IDX_W+2];
   assign up_e      = tbl[up_idx];
   assign up_hit    = up_e.valid && (up_e.tag == {{(IDX_W+2){1'b0}}, up_tag});
   assign up_tk     = upd_taken_i || upd_jump_i;
   assign up_target = upd_pc_i + upd_imm_i;

   // Allocation steps a weakly-not-taken seed once, landing on weakly taken.
   assign ctr_base = up_hit ? up_e.ctr : CTR_WNT;

   bpred_sat_counter u_ctr (
      .ctr      (ctr_base),
      .taken    (up_tk),
      .force_st (upd_jump_i),
      .ctr_next (ctr_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
            tbl[i].ctr   <= CTR_WNT;
         end
      end else if (flush_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
         end
      end else if (upd_valid_i && (up_hit || up_tk)) begin
         tbl[up_idx].valid <= 1'b1;
         tbl[up_idx].tag   <= {{(IDX_W+2){1'b0}}, up_tag};
         tbl[up_idx].ctr   <= ctr_next;
         if (up_tk) tbl[up_idx].target <= up_target;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_i;
   logic        hit_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic [31:0] upd_imm_i;
   logic        upd_taken_i;
   logic        upd_jump_i;
   logic        flush_i;

   int checks = 0;
   int errors = 0;

   branch_target_buffer #(.ENTRIES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_i          (pc_i),
      .hit_o         (hit_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_imm_i     (upd_imm_i),
      .upd_taken_i   (upd_taken_i),
      .upd_jump_i    (upd_jump_i),
      .flush_i       (flush_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic eh, input logic et, input logic [31:0] etgt);
      pc_i = pc;
      #1;
      chk({tag, "_hit"},    {31'd0, hit_o},        {31'd0, eh});
      chk({tag, "_taken"},  {31'd0, pred_taken_o}, {31'd0, et});
      chk({tag, "_target"}, pred_target_o,         etgt);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      upd_valid_i = 1'b0;
      upd_taken_i = 1'b0;
      upd_jump_i  = 1'b0;
      flush_i     = 1'b0;
      rst_n       = 1'b1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic [31:0] imm,
                          input logic tk, input logic jp);
      upd_valid_i = 1'b1;
      upd_pc_i    = pc;
      upd_imm_i   = imm;
      upd_taken_i = tk;
      upd_jump_i  = jp;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] imm,
                      input logic tk, input logic jp);
      set_upd(pc, imm, tk, jp);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; pc_i = 32'h0; upd_valid_i = 1'b0; upd_pc_i = 32'h0;
      upd_imm_i = 32'h0; upd_taken_i = 1'b0; upd_jump_i = 1'b0; flush_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      tick();

      look("reset", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);

      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      look("alloc",    32'h0000_1000, 1'b1, 1'b1, 32'h0000_1010);
      look("lowbits",  32'h0000_1003, 1'b1, 1'b1, 32'h0000_1010);

      look("alias_miss", 32'h0000_2000, 1'b0, 1'b0, 32'h0000_2004);
      upd(32'h0000_2000, 32'h40, 1'b1, 1'b0);
      look("alias_new",  32'h0000_2000, 1'b1, 1'b1, 32'h0000_2040);
      look("evicted",    32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);

      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      upd(32'h0000_1000, 32'h10, 1'b0, 1'b0);
      look("ctr_01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
      upd(32'h0000_1000, 32'h10, 1'b0, 1'b0);
      upd(32'h0000_1000, 32'h10, 1'b0, 1'b0);
      look("ctr_00", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      look("ctr_up01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      look("ctr_up10", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1010);
      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      upd(32'h0000_1000, 32'h10, 1'b0, 1'b0);
      look("sat_11", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1010);
      upd(32'h0000_1000, 32'h10, 1'b0, 1'b0);
      look("down_01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);

      upd(32'h0000_1000, 32'h20, 1'b0, 1'b1);
      upd(32'h0000_1000, 32'h20, 1'b0, 1'b0);
      look("jump_hit", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1020);
      upd(32'h0000_4004, 32'h8, 1'b0, 1'b1);
      upd(32'h0000_4004, 32'h8, 1'b0, 1'b0);
      look("jump_alloc", 32'h0000_4004, 1'b1, 1'b1, 32'h0000_400C);

      upd(32'h0000_5008, 32'h10, 1'b0, 1'b0);
      look("miss_nt", 32'h0000_5008, 1'b0, 1'b0, 32'h0000_500C);

      upd(32'h0000_3000, 32'hFFFF_FFFC, 1'b1, 1'b0);
      look("neg_imm", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_2FFC);
      upd(32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0);
      look("wrap_tgt", 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0010);
      look("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

      set_upd(32'h0000_6010, 32'h10, 1'b1, 1'b0);
      flush_i = 1'b1;
      tick();
      look("flush_a", 32'h0000_3000, 1'b0, 1'b0, 32'h0000_3004);
      look("flush_b", 32'hFFFF_FFF0, 1'b0, 1'b0, 32'hFFFF_FFF4);
      look("flush_c", 32'h0000_4004, 1'b0, 1'b0, 32'h0000_4008);
      look("flush_upd", 32'h0000_6010, 1'b0, 1'b0, 32'h0000_6014);

      set_upd(32'h0000_1000, 32'h10, 1'b1, 1'b0);
      look("byp_pre1", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
      tick();
      look("byp_post1", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1010);
      set_upd(32'h0000_1000, 32'h30, 1'b1, 1'b0);
      look("byp_pre2", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1010);
      tick();
      look("byp_post2", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1030);

      set_upd(32'h0000_7000, 32'h10, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      look("rst_old", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
      look("rst_upd", 32'h0000_7000, 1'b0, 1'b0, 32'h0000_7004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
